dm_csrs_lite: RTL and testbench

Core-side Debug Module register block that consumes DMI requests produced by the JTAG DTM after clock-domain crossing, and returns DMI responses. It implements a minimal RISC-V Debug Spec 0.13 register set: data0, dmcontrol, dmstatus, abstractcs and command. It drives halt and resume requests to a single hart and sequences abstract register-access commands over a simple request/done handshake to the core.

---
 rtl/dm_csrs_lite.sv | 181 ++++++++++++++++++
 tb/tb_dm_csrs_lite.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dm_csrs_lite.sv
// Minimal RISC-V debug module register block: DMI request/response front end,
// dmcontrol/dmstatus/abstractcs/command/data0, halt/resume and abstract register access.
module dm_csrs_lite #(
    parameter int ABITS       = 7,
    parameter int NDMRESET_EN = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               dmi_clear_i,
    input  logic [ABITS+33:0]  dmi_req_i,
    input  logic               dmi_req_valid_i,
    output logic               dmi_req_ready_o,
    output logic [33:0]        dmi_resp_o,
    output logic               dmi_resp_valid_o,
    input  logic               dmi_resp_ready_i,
    input  logic               halted_i,
    output logic               debug_req_o,
    output logic               resume_req_o,
    output logic               ndmreset_o,
    output logic               dmactive_o,
    output logic               ar_valid_o,
    output logic               ar_write_o,
    output logic [15:0]        ar_regno_o,
    output logic [31:0]        ar_wdata_o,
    input  logic               ar_done_i,
    input  logic               ar_err_i,
    input  logic [31:0]        ar_rdata_i
);
    localparam logic [ABITS-1:0] A_DATA0   = ABITS'('h04);
    localparam logic [ABITS-1:0] A_DMCTRL  = ABITS'('h10);
    localparam logic [ABITS-1:0] A_DMSTAT  = ABITS'('h11);
    localparam logic [ABITS-1:0] A_ACS     = ABITS'('h16);

    typedef enum logic {D_IDLE, D_RESP} dstate_t;
    typedef enum logic {A_IDLE, A_BUSY} astate_t;

    dstate_t r_dstate, w_dstate_nxt;
    astate_t r_astate, w_astate_nxt;

    logic [31:0] r_resp_data, r_data0, r_ar_wdata;
    logic [15:0] r_ar_regno;
    logic [2:0]  r_cmderr;
    logic        r_haltreq, r_ndmreset, r_dmactive, r_resume_req, r_resumeack, r_ar_write;

    logic [ABITS-1:0] w_addr;
    logic [31:0]      w_wd, w_rdata;
    logic [1:0]       w_op;
    logic w_acc, w_wr, w_rd, w_busy, w_done;
    logic w_wr_dmc, w_wr_data0, w_wr_acs, w_wr_cmd, w_abort, w_cmd_bad, w_cmd_start;

    assign w_addr = dmi_req_i[ABITS+33:34];
    assign w_wd   = dmi_req_i[33:2];
    assign w_op   = dmi_req_i[1:0];

    assign w_acc      = dmi_req_valid_i && (r_dstate == D_IDLE) && !dmi_clear_i;
    assign w_wr       = w_acc && (w_op == 2'd2);
    assign w_rd       = w_acc && (w_op == 2'd1);
    assign w_wr_dmc   = w_wr && (w_addr == A_DMCTRL);
    assign w_wr_data0 = w_wr && (w_addr == A_DATA0);
    assign w_wr_acs   = w_wr && (w_addr == A_ACS);
    assign w_wr_cmd   = w_wr && (w_addr == ABITS'('h17));
    assign w_busy     = (r_astate == A_BUSY);
    assign w_done     = w_busy && ar_done_i && !dmi_clear_i;
    assign w_abort    = w_wr_dmc && !w_wd[0];
    assign w_cmd_bad  = (w_wd[31:24] != 8'd0) || (w_wd[22:20] != 3'd2);
    assign w_cmd_start = w_wr_cmd && r_dmactive && !w_busy && (r_cmderr == 3'd0)
                         && !w_cmd_bad && halted_i && w_wd[17];

    always_comb begin
        w_rdata = 32'd0;
        case (w_addr)
            A_DATA0:  w_rdata = r_data0;
            A_DMCTRL: w_rdata = {r_haltreq, 29'd0, r_ndmreset, r_dmactive};
            A_DMSTAT: w_rdata = {14'd0, r_resumeack, r_resumeack, 4'd0, !halted_i, !halted_i,
                                 halted_i, halted_i, 1'b1, 3'd0, 4'd2};
            A_ACS:    w_rdata = {3'd0, 5'd0, 11'd0, w_busy, 1'b0, r_cmderr, 4'd0, 4'd1};
            default:  w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dstate <= D_IDLE;
            r_astate <= A_IDLE;
        end else begin
            r_dstate <= w_dstate_nxt;
            r_astate <= w_astate_nxt;
        end
    end

    always_comb begin
        w_dstate_nxt = r_dstate;
        case (r_dstate)
            D_IDLE:  if (w_acc) w_dstate_nxt = D_RESP;
            D_RESP:  if (dmi_resp_ready_i) w_dstate_nxt = D_IDLE;
            default: w_dstate_nxt = D_IDLE;
        endcase
        if (dmi_clear_i) w_dstate_nxt = D_IDLE;
    end

    always_comb begin
        w_astate_nxt = r_astate;
        case (r_astate)
            A_IDLE:  if (w_cmd_start) w_astate_nxt = A_BUSY;
            A_BUSY:  if (w_abort || ar_done_i) w_astate_nxt = A_IDLE;
            default: w_astate_nxt = A_IDLE;
        endcase
        if (dmi_clear_i) w_astate_nxt = A_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_resp_data  <= 32'd0;
            r_data0      <= 32'd0;
            r_haltreq    <= 1'b0;
            r_ndmreset   <= 1'b0;
            r_dmactive   <= 1'b0;
            r_resume_req <= 1'b0;
            r_resumeack  <= 1'b0;
            r_cmderr     <= 3'd0;
            r_ar_write   <= 1'b0;
            r_ar_regno   <= 16'd0;
            r_ar_wdata   <= 32'd0;
        end else begin
            if (w_acc) r_resp_data <= w_rd ? w_rdata : 32'd0;
            if (w_wr_dmc) r_dmactive <= w_wd[0];
            if (w_abort) begin
                // Deactivating the DM wipes all state it owns.
                r_haltreq    <= 1'b0;
                r_ndmreset   <= 1'b0;
                r_resume_req <= 1'b0;
                r_resumeack  <= 1'b0;
                r_data0      <= 32'd0;
                r_cmderr     <= 3'd0;
            end else begin
                if (w_wr_dmc) begin
                    r_haltreq  <= w_wd[31];
                    r_ndmreset <= w_wd[1] && (NDMRESET_EN != 0);
                end
                if (w_wr_dmc && w_wd[30] && !w_wd[31] && halted_i) begin
                    r_resume_req <= 1'b1;
                    r_resumeack  <= 1'b0;
                end else if (r_resume_req && !halted_i) begin
                    r_resume_req <= 1'b0;
                    r_resumeack  <= 1'b1;
                end
                if (w_done && !ar_err_i && !r_ar_write)
                    r_data0 <= ar_rdata_i;
                else if (w_wr_data0 && !w_busy && r_dmactive)
                    r_data0 <= w_wd;
                if (w_done && ar_err_i)
                    r_cmderr <= 3'd3;
                else if ((w_wr_cmd || w_wr_acs || w_wr_data0) && w_busy) begin
                    if (r_cmderr == 3'd0) r_cmderr <= 3'd1;
                end else if (w_wr_acs && r_dmactive)
                    r_cmderr <= r_cmderr & ~w_wd[10:8];
                else if (w_wr_cmd && r_dmactive && (r_cmderr == 3'd0)) begin
                    if (w_cmd_bad)      r_cmderr <= 3'd2;
                    else if (!halted_i) r_cmderr <= 3'd4;
                end
                if (w_cmd_start) begin
                    r_ar_write <= w_wd[16];
                    r_ar_regno <= w_wd[15:0];
                    r_ar_wdata <= r_data0;
                end
            end
        end
    end

    assign dmi_req_ready_o  = (r_dstate == D_IDLE);
    assign dmi_resp_valid_o = (r_dstate == D_RESP);
    assign dmi_resp_o       = {r_resp_data, 2'b00};
    assign debug_req_o      = r_haltreq;
    assign resume_req_o     = r_resume_req;
    assign ndmreset_o       = r_ndmreset;
    assign dmactive_o       = r_dmactive;
    assign ar_valid_o       = w_busy;
    assign ar_write_o       = r_ar_write;
    assign ar_regno_o       = r_ar_regno;
    assign ar_wdata_o       = r_ar_wdata;
endmodule

// File: tb/tb_dm_csrs_lite.sv
// Self-checking bench for dm_csrs_lite: DMI responses are scoreboarded through a queue,
// side-band outputs are checked directly after each transaction.
module tb_dm_csrs_lite;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        dmi_clear_i = 1'b0;
    logic [40:0] dmi_req_i = '0;
    logic        dmi_req_valid_i = 1'b0;
    logic        dmi_req_ready_o;
    logic [33:0] dmi_resp_o;
    logic        dmi_resp_valid_o;
    logic        dmi_resp_ready_i = 1'b0;
    logic        halted_i = 1'b0;
    logic        debug_req_o, resume_req_o, ndmreset_o, dmactive_o;
    logic        ar_valid_o, ar_write_o;
    logic [15:0] ar_regno_o;
    logic [31:0] ar_wdata_o;
    logic        ar_done_i = 1'b0;
    logic        ar_err_i = 1'b0;
    logic [31:0] ar_rdata_i = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb_q[$];

    dm_csrs_lite #(.ABITS(7), .NDMRESET_EN(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .dmi_clear_i(dmi_clear_i),
        .dmi_req_i(dmi_req_i), .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
        .dmi_resp_o(dmi_resp_o), .dmi_resp_valid_o(dmi_resp_valid_o), .dmi_resp_ready_i(dmi_resp_ready_i),
        .halted_i(halted_i), .debug_req_o(debug_req_o), .resume_req_o(resume_req_o),
        .ndmreset_o(ndmreset_o), .dmactive_o(dmactive_o),
        .ar_valid_o(ar_valid_o), .ar_write_o(ar_write_o), .ar_regno_o(ar_regno_o),
        .ar_wdata_o(ar_wdata_o), .ar_done_i(ar_done_i), .ar_err_i(ar_err_i), .ar_rdata_i(ar_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DMI idle; returns at a negedge with the DMI idle again.
    task automatic dmi(input string tag, input logic [6:0] a, input logic [31:0] d,
                       input logic [1:0] op, input logic [31:0] exp);
        int n;
        sb_q.push_back(exp);
        dmi_req_i = {a, d, op};
        dmi_req_valid_i = 1'b1;
        n = 0;
        while (!dmi_req_ready_o && n < 20) begin @(negedge clk_i); n++; end
        @(negedge clk_i);
        dmi_req_valid_i = 1'b0;
        n = 0;
        while (!dmi_resp_valid_o && n < 20) begin @(negedge clk_i); n++; end
        if (!dmi_resp_valid_o) chk({tag, "_timeout"}, 32'd0, 32'd1);
        dmi_resp_ready_i = 1'b1;
        chk(tag, dmi_resp_o[33:2], sb_q.pop_front());
        chk({tag, "_resp"}, {30'd0, dmi_resp_o[1:0]}, 32'd0);
        @(negedge clk_i);
        dmi_resp_ready_i = 1'b0;
    endtask

    task automatic ar_pulse(input logic err, input logic [31:0] rd);
        ar_done_i = 1'b1; ar_err_i = err; ar_rdata_i = rd;
        @(negedge clk_i);
        ar_done_i = 1'b0; ar_err_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_ready", {31'd0, dmi_req_ready_o}, 32'd1);
        chk("rst_outs", {26'd0, dmi_resp_valid_o, debug_req_o, resume_req_o, ndmreset_o,
                         dmactive_o, ar_valid_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Response latency and hold while resp_ready is low
        sb_q.push_back(32'h0000_0C82);
        dmi_req_i = {7'h11, 32'd0, 2'd1};
        dmi_req_valid_i = 1'b1;
        @(negedge clk_i);
        dmi_req_valid_i = 1'b0;
        chk("lat_valid", {31'd0, dmi_resp_valid_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_data", dmi_resp_o[33:2], sb_q[0]);
            chk("hold_ready", {31'd0, dmi_req_ready_o}, 32'd0);
            @(negedge clk_i);
        end
        chk("hold_valid", {31'd0, dmi_resp_valid_o}, 32'd1);
        dmi_resp_ready_i = 1'b1;
        chk("dmstatus_rst", dmi_resp_o[33:2], sb_q.pop_front());
        @(negedge clk_i);
        dmi_resp_ready_i = 1'b0;
        chk("ready_back", {31'd0, dmi_req_ready_o}, 32'd1);

        // Halt / resume
        dmi("wr_halt", 7'h10, 32'h8000_0001, 2'd2, 32'd0);
        chk("debug_req", {30'd0, debug_req_o, dmactive_o}, 32'd3);
        dmi("rd_dmctrl", 7'h10, 32'd0, 2'd1, 32'h8000_0001);
        halted_i = 1'b1;
        dmi("wr_resume", 7'h10, 32'h4000_0001, 2'd2, 32'd0);
        chk("resume_req_set", {30'd0, resume_req_o, debug_req_o}, 32'd2);
        halted_i = 1'b0;
        @(negedge clk_i);
        chk("resume_req_clr", {31'd0, resume_req_o}, 32'd0);
        dmi("dmstatus_ack", 7'h11, 32'd0, 2'd1, 32'h0003_0C82);
        halted_i = 1'b1;
        dmi("wr_halt_resume", 7'h10, 32'hC000_0001, 2'd2, 32'd0);
        chk("halt_wins", {30'd0, resume_req_o, debug_req_o}, 32'd1);
        dmi("dmstatus_halted", 7'h11, 32'd0, 2'd1, 32'h0003_0382);
        dmi("wr_unhalt", 7'h10, 32'h0000_0001, 2'd2, 32'd0);

        // Abstract read of x8
        dmi("cmd_rd", 7'h17, 32'h0022_1008, 2'd2, 32'd0);
        chk("ar_valid", {31'd0, ar_valid_o}, 32'd1);
        chk("ar_regno", {16'd0, ar_regno_o}, 32'h1008);
        chk("ar_write", {31'd0, ar_write_o}, 32'd0);
        dmi("acs_busy", 7'h16, 32'd0, 2'd1, 32'h0000_1001);
        dmi("wr_data0_busy", 7'h04, 32'h1234, 2'd2, 32'd0);
        dmi("data0_busy", 7'h04, 32'd0, 2'd1, 32'd0);
        dmi("acs_busy_err", 7'h16, 32'd0, 2'd1, 32'h0000_1101);
        ar_pulse(1'b0, 32'hCAFE_F00D);
        chk("ar_valid_done", {31'd0, ar_valid_o}, 32'd0);
        dmi("data0_rd", 7'h04, 32'd0, 2'd1, 32'hCAFE_F00D);
        dmi("acs_err1", 7'h16, 32'd0, 2'd1, 32'h0000_0101);
        dmi("cmd_ignored", 7'h17, 32'h0022_1008, 2'd2, 32'd0);
        chk("ar_valid_ign", {31'd0, ar_valid_o}, 32'd0);
        dmi("acs_w1c", 7'h16, 32'h0000_0700, 2'd2, 32'd0);
        dmi("acs_clean", 7'h16, 32'd0, 2'd1, 32'h0000_0001);

        // Abstract write with error
        dmi("cmd_wr", 7'h17, 32'h0023_1009, 2'd2, 32'd0);
        chk("ar_wdata", ar_wdata_o, 32'hCAFE_F00D);
        chk("ar_write1", {31'd0, ar_write_o}, 32'd1);
        ar_pulse(1'b1, 32'h0);
        dmi("acs_err3", 7'h16, 32'd0, 2'd1, 32'h0000_0301);
        dmi("acs_w1c3", 7'h16, 32'h0000_0700, 2'd2, 32'd0);

        // Command error priority
        halted_i = 1'b0;
        dmi("cmd_nothalted", 7'h17, 32'h0023_1000, 2'd2, 32'd0);
        chk("ar_valid_nh", {31'd0, ar_valid_o}, 32'd0);
        dmi("acs_err4", 7'h16, 32'd0, 2'd1, 32'h0000_0401);
        dmi("acs_w1c4", 7'h16, 32'h0000_0700, 2'd2, 32'd0);
        halted_i = 1'b1;
        dmi("cmd_aarsize3", 7'h17, 32'h0033_1000, 2'd2, 32'd0);
        dmi("acs_err2", 7'h16, 32'd0, 2'd1, 32'h0000_0201);
        dmi("acs_w1c2", 7'h16, 32'h0000_0700, 2'd2, 32'd0);
        dmi("cmd_notransfer", 7'h17, 32'h0020_1000, 2'd2, 32'd0);
        chk("ar_valid_nt", {31'd0, ar_valid_o}, 32'd0);
        dmi("acs_nt", 7'h16, 32'd0, 2'd1, 32'h0000_0001);

        // Unmapped, nop, write-only command
        dmi("wr_unmapped", 7'h20, 32'hFFFF_FFFF, 2'd2, 32'd0);
        dmi("rd_unmapped", 7'h20, 32'd0, 2'd1, 32'd0);
        dmi("nop", 7'h04, 32'd0, 2'd0, 32'd0);
        dmi("rd_cmd", 7'h17, 32'd0, 2'd1, 32'd0);

        // Deactivate while busy aborts and ignores the late done
        dmi("cmd_abort", 7'h17, 32'h0022_1008, 2'd2, 32'd0);
        chk("ar_valid_pre", {31'd0, ar_valid_o}, 32'd1);
        dmi("wr_deact", 7'h10, 32'd0, 2'd2, 32'd0);
        chk("ar_valid_abort", {31'd0, ar_valid_o}, 32'd0);
        ar_pulse(1'b0, 32'h5555_5555);
        dmi("wr_act", 7'h10, 32'h0000_0001, 2'd2, 32'd0);
        dmi("data0_abort", 7'h04, 32'd0, 2'd1, 32'd0);

        // dmi_clear drops a pending response
        dmi_req_i = {7'h11, 32'd0, 2'd1};
        dmi_req_valid_i = 1'b1;
        @(negedge clk_i);
        dmi_req_valid_i = 1'b0;
        dmi_clear_i = 1'b1;
        @(negedge clk_i);
        dmi_clear_i = 1'b0;
        chk("clr_valid", {31'd0, dmi_resp_valid_o}, 32'd0);
        chk("clr_ready", {31'd0, dmi_req_ready_o}, 32'd1);
        dmi("after_clr", 7'h10, 32'd0, 2'd1, 32'h0000_0001);

        // Async reset during busy
        dmi("cmd_rst", 7'h17, 32'h0022_1008, 2'd2, 32'd0);
        chk("ar_valid_prerst", {31'd0, ar_valid_o}, 32'd1);
        #1 rst_i = 1'b1;
        #1;
        chk("rst_async", {29'd0, ar_valid_o, dmactive_o, dmi_req_ready_o}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
